// File: rtl/imem_loader_if.sv
// Loader control, byte stream and memory write port; slave is the loader side.
interface imem_loader_if #(
  parameter int DATA_WIDTH    = 32,
  parameter int BYTE_WIDTH    = 8,
  parameter int ADDRESS_WIDTH = 32
);
  logic                     start;
  logic [ADDRESS_WIDTH-1:0] len;
  logic [BYTE_WIDTH-1:0]    in_data;
  logic                     in_valid;
  logic                     in_ready;
  logic                     WE;
  logic [ADDRESS_WIDTH-1:0] WA;
  logic [DATA_WIDTH-1:0]    WD;
  logic [3:0]               BE;
  logic                     busy;
  logic                     done;
  logic                     error;
  logic                     cpu_rst_hold;

  modport master (
    output start, len, in_data, in_valid,
    input  in_ready, WE, WA, WD, BE, busy, done, error, cpu_rst_hold
  );

  modport slave (
    input  start, len, in_data, in_valid,
    output in_ready, WE, WA, WD, BE, busy, done, error, cpu_rst_hold
  );
endinterface

// File: rtl/imem_loader.sv
// Boot loader: packs a little-endian byte stream into word writes from BASE_ADDR, one write the cycle after
// each 4th byte (in_ready low during it). IMEM_LOADER_CHECKSUM_EN adds a trailing mod-256 checksum byte.
module imem_loader #(
  parameter int                       DATA_WIDTH    = 32,
  parameter int                       BYTE_WIDTH    = 8,
  parameter int                       ADDRESS_WIDTH = 32,
  parameter logic [ADDRESS_WIDTH-1:0] BASE_ADDR     = 32'hBFC00000,
  parameter int                       MAX_BYTES     = 4096
) (
  input logic          clk,
  input logic          rst,
  imem_loader_if.slave bus
);
  localparam logic [ADDRESS_WIDTH-1:0] MAX_LEN = ADDRESS_WIDTH'(MAX_BYTES);

`ifdef IMEM_LOADER_CHECKSUM_EN
  typedef enum logic [2:0] {IDLE, RECV, WRITE, DONE, ERR, CSUM} state_t;
`else
  typedef enum logic [2:0] {IDLE, RECV, WRITE, DONE, ERR} state_t;
`endif

  state_t                   state;
  logic [ADDRESS_WIDTH-1:0] addr;
  logic [ADDRESS_WIDTH-1:0] byte_cnt;
  logic [ADDRESS_WIDTH-1:0] len_q;
  logic [DATA_WIDTH-1:0]    lane_buf;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [BYTE_WIDTH-1:0]    csum;
  logic [BYTE_WIDTH-1:0]    csum_nxt;
  assign csum_nxt = csum + bus.in_data;
`endif

  logic [1:0]               lane;
  logic [ADDRESS_WIDTH-1:0] cnt_nxt;
  logic [DATA_WIDTH-1:0]    buf_merged;
  logic [3:0]               be_fill;

  assign lane    = byte_cnt[1:0];
  assign cnt_nxt = byte_cnt + ADDRESS_WIDTH'(1);

  always_comb begin
    buf_merged = lane_buf;
    buf_merged[lane*BYTE_WIDTH +: BYTE_WIDTH] = bus.in_data;
    case (lane)
      2'd0:    be_fill = 4'b0001;
      2'd1:    be_fill = 4'b0011;
      2'd2:    be_fill = 4'b0111;
      default: be_fill = 4'b1111;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state            <= IDLE;
      addr             <= '0;
      byte_cnt         <= '0;
      len_q            <= '0;
      lane_buf         <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      csum             <= '0;
`endif
      bus.in_ready     <= 1'b0;
      bus.WE           <= 1'b0;
      bus.WA           <= '0;
      bus.WD           <= '0;
      bus.BE           <= '0;
      bus.busy         <= 1'b0;
      bus.done         <= 1'b0;
      bus.error        <= 1'b0;
      bus.cpu_rst_hold <= 1'b1;
    end else begin
      case (state)
        // Idle, finished and failed states all accept a new load with the same rules.
        IDLE, DONE, ERR: begin
          if (bus.start) begin
            if (bus.len == '0) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
              state            <= CSUM;
              csum             <= '0;
              bus.in_ready     <= 1'b1;
              bus.busy         <= 1'b1;
              bus.done         <= 1'b0;
              bus.error        <= 1'b0;
              bus.cpu_rst_hold <= 1'b1;
`else
              state            <= DONE;
              bus.done         <= 1'b1;
              bus.error        <= 1'b0;
              bus.cpu_rst_hold <= 1'b0;
`endif
            end else if (bus.len > MAX_LEN) begin
              state            <= ERR;
              bus.done         <= 1'b0;
              bus.error        <= 1'b1;
              bus.cpu_rst_hold <= 1'b1;
            end else begin
              state            <= RECV;
              len_q            <= bus.len;
              addr             <= BASE_ADDR;
              byte_cnt         <= '0;
              lane_buf         <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
              csum             <= '0;
`endif
              bus.in_ready     <= 1'b1;
              bus.busy         <= 1'b1;
              bus.done         <= 1'b0;
              bus.error        <= 1'b0;
              bus.cpu_rst_hold <= 1'b1;
            end
          end
        end

        RECV: begin
          if (bus.in_valid && bus.in_ready) begin
            lane_buf <= buf_merged;
            byte_cnt <= cnt_nxt;
`ifdef IMEM_LOADER_CHECKSUM_EN
            csum     <= csum_nxt;
`endif
            if (lane == 2'd3 || cnt_nxt == len_q) begin
              state        <= WRITE;
              bus.in_ready <= 1'b0;
              bus.WE       <= 1'b1;
              bus.WA       <= addr;
              bus.WD       <= buf_merged;
              bus.BE       <= be_fill;
            end
          end
        end

        WRITE: begin
          bus.WE   <= 1'b0;
          addr     <= addr + ADDRESS_WIDTH'(4);
          lane_buf <= '0;
          if (byte_cnt == len_q) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
            state            <= CSUM;
            bus.in_ready     <= 1'b1;
`else
            state            <= DONE;
            bus.busy         <= 1'b0;
            bus.done         <= 1'b1;
            bus.cpu_rst_hold <= 1'b0;
`endif
          end else begin
            state        <= RECV;
            bus.in_ready <= 1'b1;
          end
        end

`ifdef IMEM_LOADER_CHECKSUM_EN
        CSUM: begin
          if (bus.in_valid && bus.in_ready) begin
            bus.in_ready <= 1'b0;
            bus.busy     <= 1'b0;
            if (csum_nxt == '0) begin
              state            <= DONE;
              bus.done         <= 1'b1;
              bus.cpu_rst_hold <= 1'b0;
            end else begin
              state            <= ERR;
              bus.error        <= 1'b1;
            end
          end
        end
`endif

        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader; a monitor checks every WE pulse against a queue of expected writes.
module tb_imem_loader;
  typedef struct {
    logic [31:0] wa;
    logic [31:0] wd;
    logic [3:0]  be;
  } wr_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  imem_loader_if bus ();
  imem_loader dut (.clk(clk), .rst(rst), .bus(bus));

  wr_t exp_q[$];
  int  checks   = 0;
  int  failures = 0;
  int  ncyc     = 0;
  int  last_hs  = -10;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] lane_mask(input logic [3:0] be);
    logic [31:0] m;
    for (int i = 0; i < 4; i++) m[i*8 +: 8] = {8{be[i]}};
    return m;
  endfunction

  // Monitor: every write must match the next expected entry and follow a handshake by one cycle.
  initial begin
    wr_t it;
    forever begin
      @(negedge clk);
      ncyc++;
      if (bus.WE === 1'b1) begin
        if (exp_q.size() == 0) begin
          check("unexpected_we", {bus.WA, bus.BE}, '0);
        end else begin
          it = exp_q.pop_front();
          check("wr_addr", bus.WA, it.wa);
          check("wr_be", bus.BE, it.be);
          check("wr_data", bus.WD & lane_mask(it.be), it.wd);
          check("wr_latency", ncyc - last_hs, 1);
        end
      end
      if (bus.in_valid && bus.in_ready) last_hs = ncyc;
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_wr(input logic [31:0] wa, input logic [31:0] wd, input logic [3:0] be);
    wr_t it;
    it.wa = wa;
    it.wd = wd;
    it.be = be;
    exp_q.push_back(it);
  endtask

  task automatic start_load(input logic [31:0] n);
    bus.start = 1'b1;
    bus.len   = n;
    step();
    bus.start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    bus.in_valid = 1'b1;
    bus.in_data  = b;
    forever begin
      @(negedge clk);
      if (bus.in_ready === 1'b1) break;
      n++;
      if (n > 50) begin
        check("in_ready_timeout", 0, 1);
        break;
      end
    end
    step();
    bus.in_valid = 1'b0;
  endtask

  // After the final payload byte: supply the checksum if enabled, then expect DONE.
  task automatic finish_ok(input string name, input logic [7:0] sum);
`ifdef IMEM_LOADER_CHECKSUM_EN
    send_byte(8'h00 - sum);
    @(negedge clk);
`else
    if (sum === 8'hxx) $display("note: sum unknown");
    @(negedge clk);
    @(negedge clk);
`endif
    check(name, {bus.done, bus.cpu_rst_hold, bus.busy, bus.error}, 4'b1000);
    step();
  endtask

  task automatic drain_check(input string name);
    repeat (4) step();
    check(name, exp_q.size(), 0);
  endtask

  initial begin
    logic [73:0] rst_vec;
    rst_vec = {1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1};
    bus.start = 1'b0; bus.len = '0; bus.in_data = '0; bus.in_valid = 1'b0;
    step();
    @(negedge clk);
    check("reset_state", {bus.in_ready, bus.WE, bus.BE, bus.WD, bus.WA,
                          bus.busy, bus.done, bus.error, bus.cpu_rst_hold}, rst_vec);
    step();
    rst = 1'b0;
    step();

    // 1: single word, back-to-back bytes
    push_wr(32'hBFC00000, 32'h00000013, 4'hF);
    start_load(4);
    @(negedge clk);
    check("t1_busy", {bus.busy, bus.in_ready, bus.cpu_rst_hold}, 3'b111);
    step();
    send_byte(8'h13); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
    finish_ok("t1_done", 8'h13);
    drain_check("t1_no_extra_we");

    // 2: len=6 with gapped in_valid, partial final word
    push_wr(32'hBFC00000, 32'h04030201, 4'hF);
    push_wr(32'hBFC00004, 32'h00000605, 4'b0011);
    start_load(6);
    for (int i = 1; i <= 6; i++) begin
      send_byte(8'(i));
      if (i != 6) step();
    end
    finish_ok("t2_done", 8'h15);
    drain_check("t2_no_extra_we");

    // 0-length image
    start_load(0);
`ifdef IMEM_LOADER_CHECKSUM_EN
    send_byte(8'h00);
`endif
    @(negedge clk);
    check("len0_done", {bus.done, bus.cpu_rst_hold, bus.busy, bus.error}, 4'b1000);
    step();

    // 3: oversize rejected, sticky error, then recovery
    start_load(4097);
    @(negedge clk);
    check("t3_err", {bus.done, bus.cpu_rst_hold, bus.busy, bus.error, bus.in_ready}, 5'b01010);
    repeat (3) step();
    @(negedge clk);
    check("t3_err_sticky", {bus.error, bus.in_ready, bus.cpu_rst_hold}, 3'b101);
    step();
    push_wr(32'hBFC00000, 32'h44332211, 4'hF);
    start_load(4);
    send_byte(8'h11); send_byte(8'h22); send_byte(8'h33); send_byte(8'h44);
    finish_ok("t3_recover", 8'hAA);
    drain_check("t3_no_extra_we");

    // 4: reset after 5 bytes of len=8
    push_wr(32'hBFC00000, 32'h03020100, 4'hF);
    start_load(8);
    for (int i = 0; i < 5; i++) send_byte(8'(i));
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("t4_reset_outputs", {bus.in_ready, bus.WE, bus.BE, bus.WD, bus.WA,
                               bus.busy, bus.done, bus.error, bus.cpu_rst_hold}, rst_vec);
    step();
    rst = 1'b0;
    drain_check("t4_no_second_write");
    push_wr(32'hBFC00000, 32'hDDCCBBAA, 4'hF);
    start_load(4);
    send_byte(8'hAA); send_byte(8'hBB); send_byte(8'hCC); send_byte(8'hDD);
    finish_ok("t4_reload", 8'h0E);
    drain_check("t4_no_extra_we");

    // 5: start while busy is ignored
    push_wr(32'hBFC00000, 32'h13121110, 4'hF);
    push_wr(32'hBFC00004, 32'h17161514, 4'hF);
    start_load(8);
    send_byte(8'h10); send_byte(8'h11);
    start_load(2);
    for (int i = 2; i < 8; i++) send_byte(8'(8'h10 + i));
    finish_ok("t5_done", 8'h9C);
    drain_check("t5_two_writes");

`ifdef IMEM_LOADER_CHECKSUM_EN
    // 6: checksum good and bad
    push_wr(32'hBFC00000, 32'h04030201, 4'hF);
    start_load(4);
    send_byte(8'h01); send_byte(8'h02); send_byte(8'h03); send_byte(8'h04);
    send_byte(8'hF6);
    @(negedge clk);
    check("t6_csum_ok", {bus.done, bus.cpu_rst_hold, bus.busy, bus.error}, 4'b1000);
    step();
    push_wr(32'hBFC00000, 32'h04030201, 4'hF);
    start_load(4);
    send_byte(8'h01); send_byte(8'h02); send_byte(8'h03); send_byte(8'h04);
    send_byte(8'hF7);
    @(negedge clk);
    check("t6_csum_bad", {bus.done, bus.cpu_rst_hold, bus.busy, bus.error}, 4'b0101);
    drain_check("t6_write_happened");
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
